uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Configurable UART transmitter; next generation of the fixed 8N1 transmitter.
//  Adds compile-time data width, runtime parity, 1 or 2 stop bits and a runtime
//  baud divisor, plus a valid/ready input handshake for back-to-back frames.
//  Sits between the PicoRV32 MMIO/TRNG output FIFO and the board TX pin.
// PARAMETERS
//  F_CLK      100000000  system clock frequency, Hz
//  BAUD       115200     default baud rate, used when cfg_div == 0
//  DATA_BITS  8          data bits per frame, legal range 5..9
//  DIV_W      16         width of the bit-period divisor
// PORTS
//  clk         in   1          system clock, all logic on its rising edge
//  rst         in   1          synchronous reset, active-high
//  s_valid     in   1          byte offered
//  s_ready     out  1          transmitter can accept a byte this cycle
//  s_data      in   DATA_BITS  payload, sent LSB first
//  cfg_div     in   DIV_W      clocks per bit; 0 selects F_CLK/BAUD; 1 is treated as 2
//  cfg_parity  in   2          00 none, 01 even, 10 odd, 11 none
//  cfg_stop2   in   1          0 = one stop bit, 1 = two stop bits
//  tx_serial   out  1          serial line, idles high
//  tx_active   out  1          high while a frame is in flight
//  tx_done     out  1          one-cycle pulse after the last stop bit
// BEHAVIOUR
//  Reset, every output registered:
//   - during rst: tx_serial=1, s_ready=0, tx_active=0, tx_done=0.
//   - all counters are cleared and state goes to IDLE.
//   - rst mid-frame aborts the frame: line is high the next cycle and tx_done does not pulse.
//  Accept:
//   - s_ready=1 only in IDLE with rst low.
//   - a transfer happens when s_valid && s_ready.
//   - s_data, cfg_div, cfg_parity and cfg_stop2 are latched at accept.
//   - changes to any of them mid-frame are ignored.
//  Bit period DIV:
//   - DIV = (cfg_div==0) ? F_CLK/BAUD : max(cfg_div, 2).
//   - each bit is held for exactly DIV cycles.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: line 1, tx_active=0. On accept go to START, set tx_active=1, s_ready=0.
//   - START: line 0 for DIV cycles.
//   - DATA: bits 0..DATA_BITS-1, DIV cycles each. Bit index wraps to 0 on exit.
//   - PARITY: entered only if parity is even or odd.
//     even: bit = ^data. odd: bit = ~^data.
//   - STOP: line 1 for DIV cycles, or 2*DIV when cfg_stop2 is latched.
//     On the last STOP cycle go to IDLE and clear tx_active.
//  Timing:
//   - the start bit begins the cycle after accept.
//   - frame length = (1 + DATA_BITS + P + S) * DIV cycles, where P is 0/1 and S is 1/2.
//   - tx_done=1 during the first IDLE cycle after the frame, and s_ready=1 in that same cycle.
//   - back-to-back frames therefore have exactly 1 idle-high cycle between them.
//  Simultaneous events: rst wins over accept and over frame completion.
//  Width rules:
//   - bit counter is ceil(log2(DATA_BITS+1)) bits.
//   - the cycle counter is DIV_W bits, counts 0..DIV-1 and reloads at 0.
//   - DATA_BITS outside 5..9 is a compile-time error.
// STRUCTURE
//  uart_pkg holds:
//   - parity encodings: PAR_NONE, PAR_EVEN, PAR_ODD.
//   - FSM state localparams.
//   - function default_div(F_CLK, BAUD).
//  Sub-module uart_bit_timer:
//   - load/enable cycle counter with a DIV input.
//   - emits bit_end on cycle DIV-1.
//   - the FSM in uart_tx_cfg consumes bit_end.
// TESTING  (DATA_BITS=8 unless stated)
//  1. rst high 3 cycles, then low
//     -> during rst: tx_serial=1, s_ready=0, tx_active=0, tx_done=0
//     -> s_ready=1 one cycle after release.
//  2. 0xA5, div=4, no parity, 1 stop
//     -> line 0, then 1,0,1,0,0,1,0,1, then 1; each bit 4 cycles, 40 cycles total
//     -> tx_done pulses in cycle 41.
//  3. 0x07, div=4, even parity
//     -> parity bit 1, 44-cycle frame.
//     Same with odd parity -> parity bit 0.
//  4. s_valid held with 0x55 then 0xAA, div=4, cfg_stop2=1
//     -> stop lasts 8 cycles
//     -> 0xAA is accepted in the tx_done cycle
//     -> exactly 1 idle-high cycle before the 2nd start bit.
//  5. rst asserted at cycle 10 of a frame
//     -> tx_serial=1 next cycle, no tx_done
//     -> with cfg_div toggled mid-frame (no rst), timing is unchanged.
//  6. cfg_div=0 -> bit period 868 cycles. cfg_div=1 -> bit period 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the configurable UART transmitter
package uart_pkg;

    // cfg_parity encodings; 2'b11 behaves as PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // transmitter FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // bit period in clocks used when the runtime divisor is zero
    function automatic int unsigned default_div(input int unsigned f_clk, input int unsigned baud);
        return f_clk / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period cycle counter with load and enable
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load      restart the count at 0 (frame accept)
//   en        count while a frame is in flight
//   div       clocks per bit, must be >= 2
//   bit_end   high on the last cycle (count == div-1) of the current bit
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt;

    assign bit_end = en && (cnt == div - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with valid/ready input
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   s_valid      byte offered
//   s_ready      transmitter can accept a byte this cycle
//   s_data       payload, sent LSB first
//   cfg_div      clocks per bit; 0 selects F_CLK/BAUD, 1 is treated as 2
//   cfg_parity   00 none, 01 even, 10 odd, 11 none
//   cfg_stop2    0 one stop bit, 1 two stop bits
//   tx_serial    serial line, idles high
//   tx_active    high while a frame is in flight
//   tx_done      one-cycle pulse in the first idle cycle after a frame
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned F_CLK     = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter int          DATA_BITS = 8,
    parameter int          DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end

    localparam int               BIT_W   = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(default_div(F_CLK, BAUD));
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] data_sh;
    logic [DIV_W-1:0]     div_l;
    logic [DIV_W-1:0]     div_sel;
    logic [BIT_W-1:0]     bit_idx;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2_l;
    logic                 stop_second;
    logic                 accept;
    logic                 timer_en;
    logic                 bit_end;

    assign accept   = s_valid && s_ready;
    assign timer_en = (state != ST_IDLE);

    always_comb begin
        div_sel = cfg_div;
        if (cfg_div == '0) begin
            div_sel = DEF_DIV;
        end else if (cfg_div == DIV_W'(1)) begin
            div_sel = DIV_W'(2);
        end
    end

    uart_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .en      (timer_en),
        .div     (div_l),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            data_sh     <= '0;
            div_l       <= DIV_W'(2);
            bit_idx     <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2_l     <= 1'b0;
            stop_second <= 1'b0;
            s_ready     <= 1'b0;
            tx_serial   <= 1'b1;
            tx_active   <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                    s_ready   <= 1'b1;
                    if (accept) begin
                        // everything the frame depends on is captured here
                        state       <= ST_START;
                        tx_serial   <= 1'b0;
                        tx_active   <= 1'b1;
                        s_ready     <= 1'b0;
                        data_sh     <= s_data;
                        div_l       <= div_sel;
                        bit_idx     <= '0;
                        par_en      <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                        par_bit     <= (cfg_parity == PAR_ODD) ? ~^s_data : ^s_data;
                        stop2_l     <= cfg_stop2;
                        stop_second <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state     <= ST_DATA;
                        tx_serial <= data_sh[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (par_en) begin
                                state     <= ST_PARITY;
                                tx_serial <= par_bit;
                            end else begin
                                state     <= ST_STOP;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            // shift so the next bit to send is always at [0]
                            bit_idx   <= bit_idx + BIT_W'(1);
                            data_sh   <= data_sh >> 1;
                            tx_serial <= data_sh[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state     <= ST_STOP;
                        tx_serial <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop2_l && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            // ready is raised together with done so a held
                            // s_valid starts the next frame after one idle cycle
                            state       <= ST_IDLE;
                            stop_second <= 1'b0;
                            tx_active   <= 1'b0;
                            tx_done     <= 1'b1;
                            s_ready     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                    s_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard testbench for uart_tx_cfg
module tb_uart_tx_cfg;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic [15:0] cfg_div = 16'd4;
    logic [1:0]  cfg_parity = PAR_NONE;
    logic        cfg_stop2 = 1'b0;
    logic        tx_serial;
    logic        tx_active;
    logic        tx_done;

    int checks = 0;
    int passes = 0;

    // pat holds the line level per bit slot in time order (pat[0] = start bit)
    typedef struct {
        logic [0:15] pat;
        int          nb;
        int          div;
    } exp_t;

    exp_t exp_q[$];
    bit   cap[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .F_CLK     (100000000),
        .BAUD      (115200),
        .DATA_BITS (8),
        .DIV_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_serial  (tx_serial),
        .tx_active  (tx_active),
        .tx_done    (tx_done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic exp_push(input logic [0:15] pat, input int nb, input int div);
        exp_t e;
        e.pat = pat;
        e.nb  = nb;
        e.div = div;
        exp_q.push_back(e);
    endtask

    // monitor: records the line while a frame is active, scores it on tx_done
    always @(negedge clk) begin
        exp_t e;
        int   mism;
        if (rst) begin
            cap.delete();
        end else begin
            if (tx_active) cap.push_back(tx_serial);
            if (tx_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_len", cap.size(), e.nb * e.div);
                    mism = 0;
                    foreach (cap[i]) begin
                        if (i / e.div >= 16 || cap[i] !== e.pat[i / e.div]) mism++;
                    end
                    chk("frame_bits", mism, 0);
                    chk("line_high_at_done", tx_serial, 1);
                end
                cap.delete();
            end
        end
    end

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic offer(input logic [7:0] d, input logic [15:0] div,
                         input logic [1:0] par, input logic st2);
        int t;
        t = 0;
        s_data     = d;
        cfg_div    = div;
        cfg_parity = par;
        cfg_stop2  = st2;
        s_valid    = 1'b1;
        while (!s_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_in_time", (t < 20000) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_done(output int t);
        t = 0;
        while (!tx_done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("done_in_time", (t < 20000) ? 1 : 0, 1);
    endtask

    initial begin
        int t;
        int n_done;

        // reset held 3 cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_serial", tx_serial, 1);
            chk("rst_ready", s_ready, 0);
            chk("rst_active", tx_active, 0);
            chk("rst_done", tx_done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1);

        // 0xA5, div 4, 8N1
        exp_push(16'b0101001011_000000, 10, 4);
        offer(8'hA5, 16'd4, PAR_NONE, 1'b0);
        s_valid = 1'b0;
        wait_done(t);
        chk("a5_done_cycle", t, 40);
        chk("a5_ready_with_done", s_ready, 1);

        // 0x07 even parity -> parity bit 1
        @(negedge clk);
        exp_push(16'b01110000011_00000, 11, 4);
        offer(8'h07, 16'd4, PAR_EVEN, 1'b0);
        s_valid = 1'b0;
        wait_done(t);
        chk("even_done_cycle", t, 44);

        // 0x07 odd parity -> parity bit 0
        @(negedge clk);
        exp_push(16'b01110000001_00000, 11, 4);
        offer(8'h07, 16'd4, PAR_ODD, 1'b0);
        s_valid = 1'b0;
        wait_done(t);
        chk("odd_done_cycle", t, 44);

        // back-to-back 0x55 then 0xAA with two stop bits
        @(negedge clk);
        exp_push(16'b01010101011_00000, 11, 4);
        exp_push(16'b00101010111_00000, 11, 4);
        offer(8'h55, 16'd4, PAR_NONE, 1'b1);
        s_data = 8'hAA;
        wait_done(t);
        chk("b2b_first_done_cycle", t, 44);
        chk("b2b_ready_in_done", s_ready, 1);
        chk("b2b_idle_high", tx_serial, 1);
        @(negedge clk);
        chk("b2b_second_start", tx_serial, 0);
        chk("b2b_second_active", tx_active, 1);
        s_valid = 1'b0;
        wait_done(t);
        chk("b2b_second_done_cycle", t, 44);

        // reset at cycle 10 of a frame aborts it without tx_done
        @(negedge clk);
        offer(8'hFF, 16'd4, PAR_NONE, 1'b0);
        s_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_line_high", tx_serial, 1);
        chk("abort_no_done", tx_done, 0);
        chk("abort_inactive", tx_active, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_done) n_done++;
        end
        chk("abort_done_count", n_done, 0);
        chk("abort_ready_again", s_ready, 1);

        // config changes mid-frame are ignored
        exp_push(16'b0001111001_000000, 10, 4);
        offer(8'h3C, 16'd4, PAR_NONE, 1'b0);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        cfg_div    = 16'd7;
        cfg_parity = PAR_EVEN;
        cfg_stop2  = 1'b1;
        s_data     = 8'h00;
        wait_done(t);
        chk("midcfg_done_cycle", t, 35);

        // cfg_div 0 -> default 868 clocks per bit
        @(negedge clk);
        exp_push(16'b0100000011_000000, 10, 868);
        offer(8'h81, 16'd0, PAR_NONE, 1'b0);
        s_valid = 1'b0;
        wait_done(t);
        chk("div0_done_cycle", t, 8680);

        // cfg_div 1 -> 2 clocks per bit, odd parity on 0x0F -> 1
        @(negedge clk);
        exp_push(16'b01111000011_00000, 11, 2);
        offer(8'h0F, 16'd1, PAR_ODD, 1'b0);
        s_valid = 1'b0;
        wait_done(t);
        chk("div1_done_cycle", t, 22);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
